// File: rtl/level_slicer_pkg.sv
// level_slicer_pkg: shared state encoding, default widths and event word layout for level_slicer.
package level_slicer_pkg;
  typedef enum logic [1:0] {LOW, RISE_PEND, HIGH, FALL_PEND} state_t;
  localparam int DEF_HOLD_W = 8;
  localparam int DEF_TS_W = 16;
  // Event word is {rise, ts}: timestamp from EVT_TS_LSB, rise bit directly above it.
  localparam int EVT_TS_LSB = 0;
endpackage

// File: rtl/evt_slot.sv
// evt_slot: single-entry valid/ready event register; a new event arriving while one is stalled is dropped and flags ovf.
module evt_slot
  import level_slicer_pkg::*;
#(
  parameter int TS_W = DEF_TS_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            push_rise,
  input  logic [TS_W-1:0] push_time,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic            evt_rise,
  output logic [TS_W-1:0] evt_time,
  output logic            ovf,
  input  logic            ovf_clr
);
  logic [EVT_TS_LSB+TS_W:0] word;
  logic xfer, load, drop;
  assign xfer = evt_valid && evt_ready;
  assign load = push && (!evt_valid || xfer);
  assign drop = push && evt_valid && !evt_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid <= 1'b0;
      word <= '0;
      ovf <= 1'b0;
    end else begin
      evt_valid <= load || (evt_valid && !xfer);
      if (load) word <= {push_rise, push_time};
      ovf <= drop || (ovf && !ovf_clr);
    end
  end
  assign evt_rise = word[EVT_TS_LSB+TS_W];
  assign evt_time = word[EVT_TS_LSB +: TS_W];
endmodule

// File: rtl/level_slicer.sv
// level_slicer: hysteresis + hold-count debouncer producing a sliced level and rise/fall events.
// Define LEVEL_SLICER_TS_EN to timestamp events; otherwise evt_time is 0.
module level_slicer
  import level_slicer_pkg::*;
#(
  parameter int HOLD_W = DEF_HOLD_W,
  parameter int TS_W = DEF_TS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       din,
  input  logic [15:0]       thr_hi,
  input  logic [15:0]       thr_lo,
  input  logic [HOLD_W-1:0] hold,
  output logic              level,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_rise,
  output logic [TS_W-1:0]   evt_time,
  output logic              ovf,
  input  logic              ovf_clr
);
  state_t state, nstate;
  logic [HOLD_W-1:0] cnt, ncnt;
  logic nlevel;
  logic [TS_W-1:0] ts_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOW;
      cnt <= '0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
    end
  end
  // Each state compares only against its own threshold, even if thr_lo > thr_hi.
  always_comb begin
    nstate = state;
    ncnt = cnt;
    case (state)
      LOW: if (din >= thr_hi) begin
        nstate = hold == '0 ? HIGH : RISE_PEND;
        ncnt = hold == '0 ? '0 : HOLD_W'(1);
      end
      RISE_PEND: begin
        nstate = din < thr_hi ? LOW : cnt == hold ? HIGH : RISE_PEND;
        ncnt = (din < thr_hi || cnt == hold) ? '0 : cnt + HOLD_W'(1);
      end
      HIGH: if (din < thr_lo) begin
        nstate = hold == '0 ? LOW : FALL_PEND;
        ncnt = hold == '0 ? '0 : HOLD_W'(1);
      end
      FALL_PEND: begin
        nstate = din >= thr_lo ? HIGH : cnt == hold ? LOW : FALL_PEND;
        ncnt = (din >= thr_lo || cnt == hold) ? '0 : cnt + HOLD_W'(1);
      end
    endcase
  end
  always_comb begin
    level = state == HIGH || state == FALL_PEND;
    nlevel = nstate == HIGH || nstate == FALL_PEND;
  end
`ifdef LEVEL_SLICER_TS_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk) ts <= rst ? '0 : ts + TS_W'(1);
  // Events carry the count of the cycle in which the new level is visible.
  assign ts_next = ts + TS_W'(1);
`else
  assign ts_next = '0;
`endif
  evt_slot #(.TS_W(TS_W)) u_slot (
    .clk(clk),
    .rst(rst),
    .push(nlevel != level),
    .push_rise(nlevel),
    .push_time(ts_next),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_rise(evt_rise),
    .evt_time(evt_time),
    .ovf(ovf),
    .ovf_clr(ovf_clr)
  );
endmodule
